// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel pacer: fill FSM states,
// packed pixel-word field offsets and default parameter values.
package vga_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    // Bit positions inside the packed sync/blank/colour-index pixel word
    localparam int HSYNC_BIT = 11;
    localparam int VSYNC_BIT = 10;
    localparam int VON_H_BIT = 9;
    localparam int VON_V_BIT = 8;
    localparam int CHAR_LSB  = 0;

    localparam int DEF_DW       = 12;
    localparam int DEF_AW       = 4;
    localparam int DEF_LO_WM    = 7;
    localparam int DEF_HI_WM    = 8;
    localparam int DEF_MEM_PIPE = 4;
    localparam int DEF_DIV_W    = 2;

endpackage

// File: rtl/vga_pacer_fifo.sv
// First-word-fall-through pixel buffer, DW x 2**AW, with occupancy,
// full and empty status derived from extended read/write pointers.
module vga_pacer_fifo #(
    parameter int DW = 12,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem_q [2**AW];
    logic [AW:0]   wr_q;
    logic [AW:0]   rd_q;
    logic          do_push;
    logic          do_pop;

    assign level_o = wr_q - rd_q;
    assign full_o  = (level_o == DEPTH);
    assign empty_o = (level_o == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/vga_pixel_pacer.sv
// Pixel-buffer flow controller: watermark-hysteresis fill FSM, in-flight strobe
// pipe, programmable dot divider. Underflow flag/counter under VGA_PIXEL_PACER_UNDERFLOW_EN.
module vga_pixel_pacer
    import vga_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AW       = DEF_AW,
    parameter int LO_WM    = DEF_LO_WM,
    parameter int HI_WM    = DEF_HI_WM,
    parameter int MEM_PIPE = DEF_MEM_PIPE,
    parameter int DIV_W    = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] dot_div,
    input  logic [DW-1:0]    prod_dat_i,
    input  logic             stb_i,
    output logic             stb_o,
    output logic             prod_en_o,
    output logic             cons_en_o,
    output logic [DW-1:0]    cons_dat_o,
    output logic [AW:0]      level_o,
    input  logic             clr_underflow,
    output logic             underflow_o,
    output logic [7:0]       underflow_cnt_o
);

    localparam logic [AW:0] LO_LVL = (AW+1)'(LO_WM);
    localparam logic [AW:0] HI_LVL = (AW+1)'(HI_WM);

    fill_state_e         state_q;
    logic [DIV_W-1:0]    dcnt_q, dcnt_d;
    logic [MEM_PIPE-1:0] mem_p_q, mem_p_d;
    logic                cons_en_q;
    logic [DW-1:0]       cons_dat_q;
    logic [DW-1:0]       head;
    logic                full, empty;
    logic                pipe_active, pop_req, fifo_pop;

    vga_pacer_fifo #(.DW(DW), .AW(AW)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (prod_en_o),
        .wdata_i(prod_dat_i),
        .pop_i  (fifo_pop),
        .rdata_o(head),
        .level_o(level_o),
        .full_o (full),
        .empty_o(empty)
    );

    // Producer keeps running while strobes already issued are still in flight
    assign pipe_active = |mem_p_q;
    assign prod_en_o   = ((state_q == FILL) | pipe_active) & ~full;
    assign stb_o       = stb_i & prod_en_o;
    assign pop_req     = (dcnt_q >= dot_div);
    assign fifo_pop    = pop_req & ~empty;
    assign cons_en_o   = cons_en_q;
    assign cons_dat_o  = cons_dat_q;

    always_comb begin
        dcnt_d  = pop_req ? '0 : dcnt_q + 1'b1;
        mem_p_d = mem_p_q;
        if (prod_en_o) mem_p_d = (mem_p_q << 1) | MEM_PIPE'(stb_o);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (level_o <= LO_LVL) state_q <= FILL;
                FILL:    if (level_o >= HI_LVL) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Consumer pulses even on an empty pop so display timing never slips
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt_q     <= '0;
            mem_p_q    <= '0;
            cons_en_q  <= 1'b0;
            cons_dat_q <= '0;
        end else begin
            dcnt_q    <= dcnt_d;
            mem_p_q   <= mem_p_d;
            cons_en_q <= pop_req;
            if (fifo_pop) cons_dat_q <= head;
        end
    end

`ifdef VGA_PIXEL_PACER_UNDERFLOW_EN
    logic       uf_q;
    logic [7:0] uf_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uf_q     <= 1'b0;
            uf_cnt_q <= '0;
        end else if (clr_underflow) begin
            uf_q     <= 1'b0;
            uf_cnt_q <= '0;
        end else if (pop_req && empty) begin
            uf_q <= 1'b1;
            if (uf_cnt_q != 8'hFF) uf_cnt_q <= uf_cnt_q + 8'd1;
        end
    end

    assign underflow_o     = uf_q;
    assign underflow_cnt_o = uf_cnt_q;
`else
    logic unused_clr;

    assign unused_clr      = clr_underflow;
    assign underflow_o     = 1'b0;
    assign underflow_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vga_pixel_pacer.sv
// Directed self-checking bench for vga_pixel_pacer at default parameters.
module tb_vga_pixel_pacer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  dot_div;
    logic [11:0] prod_dat_i;
    logic        stb_i;
    logic        stb_o;
    logic        prod_en_o;
    logic        cons_en_o;
    logic [11:0] cons_dat_o;
    logic [4:0]  level_o;
    logic        clr_underflow;
    logic        underflow_o;
    logic [7:0]  underflow_cnt_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

`ifdef VGA_PIXEL_PACER_UNDERFLOW_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    vga_pixel_pacer dut (
        .clk            (clk),
        .rst            (rst),
        .dot_div        (dot_div),
        .prod_dat_i     (prod_dat_i),
        .stb_i          (stb_i),
        .stb_o          (stb_o),
        .prod_en_o      (prod_en_o),
        .cons_en_o      (cons_en_o),
        .cons_dat_o     (cons_dat_o),
        .level_o        (level_o),
        .clr_underflow  (clr_underflow),
        .underflow_o    (underflow_o),
        .underflow_cnt_o(underflow_cnt_o)
    );

    always #5 clk = ~clk;

    // Advance one cycle; the producer word moves on only after it was pushed
    task automatic step();
        logic pe;
        pe = prod_en_o;
        @(posedge clk);
        #1;
        if (pe) prod_dat_i = prod_dat_i + 12'd1;
        cyc++;
    endtask

    task automatic do_reset(input logic [11:0] base, input logic [1:0] div);
        rst           = 1'b1;
        stb_i         = 1'b0;
        clr_underflow = 1'b0;
        prod_dat_i    = base;
        dot_div       = div;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stb_i = 1'b1; dot_div = 2'd3; prod_dat_i = 12'h5A5; clr_underflow = 1'b0;
        #1;
        tests++;
        if ({prod_en_o, stb_o, cons_en_o, cons_dat_o, level_o, underflow_o, underflow_cnt_o} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got pe=%0b stb=%0b ce=%0b dat=%0h lvl=%0d uf=%0b cnt=%0d expected all 0",
                     prod_en_o, stb_o, cons_en_o, cons_dat_o, level_o, underflow_o, underflow_cnt_o);
        end
        @(posedge clk);
        #1;
        tests++;
        if ({prod_en_o, cons_en_o, level_o} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_held: got pe=%0b ce=%0b lvl=%0d expected 0", prod_en_o, cons_en_o, level_o);
        end
    endtask

    task automatic test_fill();
        do_reset(12'h000, 2'd3);
        while (cyc < 12) begin
            if (cyc == 0 || cyc == 1) begin
                tests++;
                if (prod_en_o !== (cyc == 1)) begin
                    fails++;
                    $display("[TB] FAIL fill_prod_en c%0d: got %0b expected %0b", cyc, prod_en_o, cyc == 1);
                end
            end
            if (cyc == 4 || cyc == 8) begin
                tests++;
                if (cons_en_o !== 1'b1 || cons_dat_o !== ((cyc == 4) ? 12'h000 : 12'h001)) begin
                    fails++;
                    $display("[TB] FAIL fill_cons c%0d: got ce=%0b dat=%0h expected ce=1 dat=%0h",
                             cyc, cons_en_o, cons_dat_o, (cyc == 4) ? 0 : 1);
                end
            end
            if (cyc == 5 || cyc == 7) begin
                tests++;
                if (cons_en_o !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL fill_cons_idle c%0d: got %0b expected 0", cyc, cons_en_o);
                end
            end
            tests++;
            if (level_o > 5'd12) begin
                fails++;
                $display("[TB] FAIL fill_level_max c%0d: got %0d expected <=12", cyc, level_o);
            end
            step();
        end
    endtask

    // Continues from cycle 12 of test_fill
    task automatic test_hysteresis();
        logic exp_pe;
        while (cyc <= 26) begin
            exp_pe = (cyc == 17 || cyc == 18 || cyc == 25 || cyc == 26);
            tests++;
            if (prod_en_o !== exp_pe) begin
                fails++;
                $display("[TB] FAIL hyst_prod_en c%0d: got %0b expected %0b", cyc, prod_en_o, exp_pe);
            end
            if (cyc == 12 || cyc == 16 || cyc == 19 || cyc == 24) begin
                tests++;
                if (level_o !== ((cyc == 12) ? 5'd8 : (cyc == 19) ? 5'd9 : 5'd7)) begin
                    fails++;
                    $display("[TB] FAIL hyst_level c%0d: got %0d", cyc, level_o);
                end
            end
            if (cyc == 12) begin
                tests++;
                if (cons_en_o !== 1'b1 || cons_dat_o !== 12'h002) begin
                    fails++;
                    $display("[TB] FAIL hyst_cons c12: got ce=%0b dat=%0h expected ce=1 dat=2", cons_en_o, cons_dat_o);
                end
            end
            step();
        end
    endtask

    task automatic test_strobe_retire();
        do_reset(12'h000, 2'd3);
        while (cyc < 11) step();
        stb_i = 1'b1;
        #1;
        tests++;
        if (stb_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL strobe_pass: got %0b expected 1", stb_o);
        end
        step();
        stb_i = 1'b0;
        while (cyc < 16) begin
            tests++;
            if (prod_en_o !== 1'b1) begin
                fails++;
                $display("[TB] FAIL strobe_hold c%0d: got %0b expected 1", cyc, prod_en_o);
            end
            step();
        end
        tests++;
        if (prod_en_o !== 1'b0 || level_o !== 5'd11) begin
            fails++;
            $display("[TB] FAIL strobe_drop: got pe=%0b lvl=%0d expected pe=0 lvl=11", prod_en_o, level_o);
        end
        stb_i = 1'b1;
        #1;
        tests++;
        if (stb_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL strobe_gate: got %0b expected 0", stb_o);
        end
        stb_i = 1'b0;
    endtask

    task automatic test_full_stall();
        logic [11:0] exp_word;
        bit reached;
        exp_word = 12'h000;
        reached  = 1'b0;
        do_reset(12'h000, 2'd3);
        stb_i = 1'b1;
        for (int i = 0; i < 120; i++) begin
            if (cons_en_o) begin
                tests++;
                if (cons_dat_o !== exp_word) begin
                    fails++;
                    $display("[TB] FAIL full_order c%0d: got %0h expected %0h", cyc, cons_dat_o, exp_word);
                end
                exp_word = exp_word + 12'd1;
            end
            if (level_o == 5'd16 && !reached) begin
                reached = 1'b1;
                tests++;
                if (prod_en_o !== 1'b0 || stb_o !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL full_stall: got pe=%0b stb=%0b expected 0 0", prod_en_o, stb_o);
                end
            end
            if (level_o > 5'd16) begin
                tests++;
                fails++;
                $display("[TB] FAIL full_overflow c%0d: got %0d expected <=16", cyc, level_o);
            end
            step();
        end
        tests++;
        if (!reached) begin
            fails++;
            $display("[TB] FAIL full_reached: got level %0d expected 16 within budget", level_o);
        end
    endtask

    task automatic test_reset_midrun();
        rst = 1'b1;
        #2;
        tests++;
        if ({prod_en_o, stb_o, cons_en_o, cons_dat_o, level_o, underflow_o, underflow_cnt_o} !== '0) begin
            fails++;
            $display("[TB] FAIL midrun_reset: got pe=%0b stb=%0b ce=%0b dat=%0h lvl=%0d expected all 0",
                     prod_en_o, stb_o, cons_en_o, cons_dat_o, level_o);
        end
    endtask

    task automatic test_underflow();
        do_reset(12'h100, 2'd1);
        step();
        step();
        tests++;
        if (cons_en_o !== 1'b1 || cons_dat_o !== 12'h000) begin
            fails++;
            $display("[TB] FAIL uf_pulse: got ce=%0b dat=%0h expected ce=1 dat=0", cons_en_o, cons_dat_o);
        end
        tests++;
        if (underflow_o !== UF_EN || underflow_cnt_o !== (UF_EN ? 8'd1 : 8'd0)) begin
            fails++;
            $display("[TB] FAIL uf_flag: got uf=%0b cnt=%0d expected uf=%0b cnt=%0d",
                     underflow_o, underflow_cnt_o, UF_EN, UF_EN ? 1 : 0);
        end
        step();
        step();
        tests++;
        if (cons_en_o !== 1'b1 || cons_dat_o !== 12'h100 || underflow_cnt_o !== (UF_EN ? 8'd1 : 8'd0)) begin
            fails++;
            $display("[TB] FAIL uf_recover: got ce=%0b dat=%0h cnt=%0d expected ce=1 dat=100 cnt=%0d",
                     cons_en_o, cons_dat_o, underflow_cnt_o, UF_EN ? 1 : 0);
        end
        clr_underflow = 1'b1;
        step();
        clr_underflow = 1'b0;
        tests++;
        if (underflow_o !== 1'b0 || underflow_cnt_o !== 8'd0) begin
            fails++;
            $display("[TB] FAIL uf_clear: got uf=%0b cnt=%0d expected 0 0", underflow_o, underflow_cnt_o);
        end
    endtask

    task automatic test_clear_wins();
        do_reset(12'h200, 2'd1);
        step();
        clr_underflow = 1'b1;
        step();
        clr_underflow = 1'b0;
        tests++;
        if (cons_en_o !== 1'b1 || underflow_o !== 1'b0 || underflow_cnt_o !== 8'd0) begin
            fails++;
            $display("[TB] FAIL clear_wins: got ce=%0b uf=%0b cnt=%0d expected 1 0 0",
                     cons_en_o, underflow_o, underflow_cnt_o);
        end
    endtask

    task automatic test_divider_change();
        do_reset(12'h300, 2'd3);
        step();
        step();
        tests++;
        if (cons_en_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL div_before: got %0b expected 0", cons_en_o);
        end
        dot_div = 2'd0;
        step();
        while (cyc <= 12) begin
            tests++;
            if (cons_en_o !== 1'b1) begin
                fails++;
                $display("[TB] FAIL div_every_cycle c%0d: got %0b expected 1", cyc, cons_en_o);
            end
            if (cyc <= 5) begin
                tests++;
                if (cons_dat_o !== 12'h300 + 12'(cyc - 3)) begin
                    fails++;
                    $display("[TB] FAIL div_data c%0d: got %0h expected %0h", cyc, cons_dat_o, 12'h300 + 12'(cyc - 3));
                end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hysteresis();
        test_strobe_retire();
        test_full_stall();
        test_reset_midrun();
        test_underflow();
        test_clear_wins();
        test_divider_change();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
